dma_wr_engine: RTL and testbench

DMA_WR_ENGINE -- requirements
Module: dma_wr_engine

---
 rtl/dma_wr_engine_pkg.sv | 29 ++
 rtl/dma_wr_engine_if.sv | 33 +++
 rtl/dma_wr_engine_rq_desc_pack.sv | 19 +
 rtl/dma_wr_engine.sv | 145 ++++++++++++++
 tb/tb_dma_wr_engine.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_wr_engine_pkg.sv
// Shared types and constants for the DMA write engine: FSM encoding,
// requester-request descriptor layout and the PCIe 4 KB boundary.
package dma_wr_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int RQ_DATA_W = 128;
    localparam int RQ_KEEP_W = 4;
    localparam int RQ_USER_W = 60;

    localparam logic [3:0] REQ_TYPE_MEMWR = 4'b0001;

    localparam int DESC_ADDR_LSB    = 2;
    localparam int DESC_DWCNT_LSB   = 64;
    localparam int DESC_REQTYPE_LSB = 75;
    localparam int DESC_TAG_LSB     = 96;

    localparam int unsigned BOUNDARY_4K = 4096;

    // Every TLP is whole dwords, so both byte enables are always full.
    localparam logic [RQ_USER_W-1:0] RQ_USER_FULL_BE = {52'b0, 4'hF, 4'hF};

endpackage

// File: rtl/dma_wr_engine_if.sv
// Source write-data stream and PCIe requester-request stream, bundled.
// The engine uses the master view; the data source and PCIe core the slave view.
interface dma_wr_engine_if;
    import dma_wr_engine_pkg::*;

    logic [RQ_DATA_W-1:0] src_tdata;
    logic                 src_tvalid;
    logic                 src_tready;

    logic [RQ_DATA_W-1:0] s_axis_rq_tdata;
    logic [RQ_KEEP_W-1:0] s_axis_rq_tkeep;
    logic                 s_axis_rq_tlast;
    logic                 s_axis_rq_tvalid;
    logic [RQ_USER_W-1:0] s_axis_rq_tuser;
    logic                 s_axis_rq_tready;

    modport master (
        input  src_tdata, src_tvalid,
        output src_tready,
        output s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast,
        output s_axis_rq_tvalid, s_axis_rq_tuser,
        input  s_axis_rq_tready
    );

    modport slave (
        output src_tdata, src_tvalid,
        input  src_tready,
        input  s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast,
        input  s_axis_rq_tvalid, s_axis_rq_tuser,
        output s_axis_rq_tready
    );

endinterface

// File: rtl/dma_wr_engine_rq_desc_pack.sv
// Combinational builder for the 128-bit MemWr requester descriptor beat.
module dma_wr_engine_rq_desc_pack
    import dma_wr_engine_pkg::*;
(
    input  logic [29:0]          dw_addr,
    input  logic [10:0]          dw_count,
    input  logic [7:0]           tag,
    output logic [RQ_DATA_W-1:0] desc
);

    always_comb begin
        desc = '0;
        desc[DESC_ADDR_LSB    +: 62] = 62'(dw_addr);
        desc[DESC_DWCNT_LSB   +: 11] = dw_count;
        desc[DESC_REQTYPE_LSB +: 4]  = REQ_TYPE_MEMWR;
        desc[DESC_TAG_LSB     +: 8]  = tag;
    end

endmodule

// File: rtl/dma_wr_engine.sv
// Splits a host write into MemWr TLPs bounded by MAX_PAYLOAD and 4 KB pages,
// emitting a descriptor beat per TLP and then passing source data straight through.
module dma_wr_engine
    import dma_wr_engine_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int MAX_PAYLOAD  = 256
)
(
    input  logic                  pcie_clk,
    input  logic                  pcie_rst_n,
    input  logic                  dma_wr_start,
    input  logic [31:0]           dma_wr_addr,
    input  logic [31:0]           dma_wr_len,
    dma_wr_engine_if.master       bus,
    output logic                  dma_wr_busy,
    output logic                  dma_wr_done
);

    if (C_DATA_WIDTH != RQ_DATA_W) begin : g_bad_width
        $error("dma_wr_engine: only C_DATA_WIDTH=128 is supported");
    end
    if (MAX_PAYLOAD < 16 || MAX_PAYLOAD > 512 || (MAX_PAYLOAD & (MAX_PAYLOAD - 1)) != 0) begin : g_bad_mps
        $error("dma_wr_engine: MAX_PAYLOAD must be a power of two in 16..512");
    end

    state_e               state;
    logic [31:0]          cur_addr;
    logic [31:0]          remaining;
    logic [12:0]          chunk;
    logic [8:0]           beat_cnt;
    logic [7:0]           tag;
    logic                 busy;
    logic                 done;
    logic [8:0]           last_beat;
    logic                 beat_fire;
    logic [RQ_DATA_W-1:0] desc;
    logic                 unused_low;

    // Bytes for the next TLP: limited by what is left, the payload cap and the page end.
    function automatic logic [12:0] calc_chunk(input logic [31:0] rem, input logic [11:0] addr_lo);
        logic [12:0] room;
        logic [12:0] lim;
        room = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
        lim  = 13'(MAX_PAYLOAD);
        if (room < lim)
            lim = room;
        if (rem < {19'b0, lim})
            lim = rem[12:0];
        return lim;
    endfunction

    assign last_beat   = chunk[12:4] - 9'd1;
    assign beat_fire   = bus.src_tvalid && bus.s_axis_rq_tready;
    assign unused_low  = ^{dma_wr_addr[3:0], dma_wr_len[3:0]};
    assign dma_wr_busy = busy;
    assign dma_wr_done = done;

    dma_wr_engine_rq_desc_pack u_desc (
        .dw_addr  (cur_addr[31:2]),
        .dw_count (chunk[12:2]),
        .tag      (tag),
        .desc     (desc)
    );

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            chunk     <= '0;
            beat_cnt  <= '0;
            tag       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dma_wr_start) begin
                        busy      <= 1'b1;
                        cur_addr  <= {dma_wr_addr[31:4], 4'b0};
                        remaining <= {dma_wr_len[31:4], 4'b0};
                        state     <= (dma_wr_len[31:4] != '0) ? ST_CALC : ST_DONE;
                    end
                end
                ST_CALC: begin
                    chunk    <= calc_chunk(remaining, cur_addr[11:0]);
                    beat_cnt <= '0;
                    state    <= ST_HDR;
                end
                ST_HDR: begin
                    if (bus.s_axis_rq_tready)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        if (beat_cnt == last_beat) begin
                            cur_addr  <= cur_addr + 32'(chunk);
                            remaining <= remaining - 32'(chunk);
                            tag       <= tag + 8'd1;
                            state     <= (remaining != 32'(chunk)) ? ST_CALC : ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state so an asynchronous reset clears them at once.
    always_comb begin
        bus.s_axis_rq_tvalid = 1'b0;
        bus.s_axis_rq_tdata  = '0;
        bus.s_axis_rq_tkeep  = '0;
        bus.s_axis_rq_tlast  = 1'b0;
        bus.s_axis_rq_tuser  = '0;
        bus.src_tready       = 1'b0;
        case (state)
            ST_HDR: begin
                bus.s_axis_rq_tvalid = 1'b1;
                bus.s_axis_rq_tdata  = desc;
                bus.s_axis_rq_tkeep  = '1;
                bus.s_axis_rq_tuser  = RQ_USER_FULL_BE;
            end
            ST_DATA: begin
                bus.s_axis_rq_tvalid = bus.src_tvalid;
                bus.s_axis_rq_tdata  = bus.src_tdata;
                bus.s_axis_rq_tkeep  = '1;
                bus.s_axis_rq_tlast  = (beat_cnt == last_beat);
                bus.s_axis_rq_tuser  = RQ_USER_FULL_BE;
                bus.src_tready       = bus.s_axis_rq_tready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_wr_engine.sv
// Randomized bench for dma_wr_engine: a queue-based model predicts every RQ beat
// (descriptor + payload) from the source words and the TLP splitting rules.
module tb_dma_wr_engine;
    localparam int MAX_PAYLOAD = 256;

    logic        pcie_clk = 1'b0;
    logic        pcie_rst_n = 1'b0;
    logic        dma_wr_start = 1'b0;
    logic [31:0] dma_wr_addr = '0;
    logic [31:0] dma_wr_len = '0;
    logic        dma_wr_busy;
    logic        dma_wr_done;

    dma_wr_engine_if bus();

    dma_wr_engine #(.C_DATA_WIDTH(128), .MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .pcie_clk     (pcie_clk),
        .pcie_rst_n   (pcie_rst_n),
        .dma_wr_start (dma_wr_start),
        .dma_wr_addr  (dma_wr_addr),
        .dma_wr_len   (dma_wr_len),
        .bus          (bus),
        .dma_wr_busy  (dma_wr_busy),
        .dma_wr_done  (dma_wr_done)
    );

    always #5 pcie_clk = ~pcie_clk;

    typedef struct { logic [127:0] data; logic last; logic hdr; } beat_t;
    typedef struct { logic [31:0] addr; int dw; int tag; } hdr_t;

    beat_t        exp_q[$];
    hdr_t         obs_q[$];
    logic [127:0] src_mem [0:511];
    int           src_n = 0;
    int           src_idx = 0;
    bit           stall_en = 1'b0;
    bit           src_fire = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;
    int           done_cnt = 0;
    int           dbeats = 0;
    int           tag_m = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: walk the byte range in TLP-sized chunks and queue the beats each must produce.
    task automatic load_model(input logic [31:0] addr, input logic [31:0] len);
        longint unsigned a;
        longint unsigned rem;
        int c;
        int room;
        int w;
        a = longint'(addr & 32'hFFFF_FFF0);
        rem = longint'(len & 32'hFFFF_FFF0);
        src_n = int'(rem / 16);
        src_idx = 0;
        w = 0;
        for (int i = 0; i < src_n; i++)
            src_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        while (rem > 0) begin
            room = 4096 - int'(a % 4096);
            c = (rem < MAX_PAYLOAD) ? int'(rem) : MAX_PAYLOAD;
            if (room < c) c = room;
            exp_q.push_back('{data: 128'(a) | (128'(c / 4) << 64) | (128'(1) << 75) | (128'(tag_m) << 96),
                              last: 1'b0, hdr: 1'b1});
            for (int b = 0; b < c / 16; b++) begin
                exp_q.push_back('{data: src_mem[w], last: (b == c / 16 - 1), hdr: 1'b0});
                w++;
            end
            a = (a + longint'(c)) % 64'h1_0000_0000;
            rem -= longint'(c);
            tag_m = (tag_m + 1) % 256;
        end
    endtask

    // Source and PCIe-core ready driver.
    initial begin
        bus.src_tvalid = 1'b0;
        bus.src_tdata = '0;
        bus.s_axis_rq_tready = 1'b0;
        forever begin
            @(posedge pcie_clk);
            #1;
            if (src_fire) src_idx++;
            if (src_idx < src_n) begin
                if (!bus.src_tvalid || src_fire)
                    bus.src_tvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.src_tdata = src_mem[src_idx];
            end else begin
                bus.src_tvalid = 1'b0;
            end
            bus.s_axis_rq_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: every accepted RQ beat against the model, plus stall stability and done shape.
    initial begin
        beat_t        e;
        bit           prev_stall = 1'b0;
        bit           prev_done = 1'b0;
        logic [127:0] prev_data = '0;
        logic         prev_last = 1'b0;
        forever begin
            @(negedge pcie_clk);
            if (!pcie_rst_n) begin
                prev_stall = 1'b0;
                prev_done = 1'b0;
                src_fire = 1'b0;
            end else begin
                src_fire = bus.src_tvalid && bus.src_tready;
                if (prev_stall) begin
                    check_val("hold_valid", 128'(bus.s_axis_rq_tvalid), 128'(1));
                    check_val("hold_data", bus.s_axis_rq_tdata, prev_data);
                    check_val("hold_last", 128'(bus.s_axis_rq_tlast), 128'(prev_last));
                end
                if (bus.s_axis_rq_tvalid && bus.s_axis_rq_tready) begin
                    check_val("beat_expected", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val(e.hdr ? "hdr_data" : "payload_data", bus.s_axis_rq_tdata, e.data);
                        check_val("tlast", 128'(bus.s_axis_rq_tlast), 128'(e.last));
                        check_val("tkeep", 128'(bus.s_axis_rq_tkeep), 128'(4'hF));
                        check_val("tuser", 128'(bus.s_axis_rq_tuser), 128'(8'hFF));
                        if (e.hdr) begin
                            check_val("hdr_src_tready", 128'(bus.src_tready), 128'(0));
                            obs_q.push_back('{addr: bus.s_axis_rq_tdata[31:0],
                                              dw: int'(bus.s_axis_rq_tdata[74:64]),
                                              tag: int'(bus.s_axis_rq_tdata[103:96])});
                        end else begin
                            dbeats++;
                        end
                    end
                end
                prev_stall = bus.s_axis_rq_tvalid && !bus.s_axis_rq_tready;
                prev_data = bus.s_axis_rq_tdata;
                prev_last = bus.s_axis_rq_tlast;
                if (dma_wr_done) begin
                    done_cnt++;
                    check_val("done_width", 128'(prev_done), 128'(0));
                    check_val("done_drain", 128'(exp_q.size()), 128'(0));
                end
                prev_done = dma_wr_done;
            end
        end
    end

    task automatic do_reset();
        @(negedge pcie_clk);
        pcie_rst_n = 1'b0;
        exp_q.delete();
        src_n = 0;
        src_idx = 0;
        tag_m = 0;
        repeat (2) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
    endtask

    task automatic pulse_start(input logic [31:0] addr, input logic [31:0] len);
        @(posedge pcie_clk);
        #2;
        dma_wr_start = 1'b1;
        dma_wr_addr = addr;
        dma_wr_len = len;
        @(posedge pcie_clk);
        #2;
        dma_wr_start = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len,
                            input bit stall, input bit lat, input bit poke);
        int  d0;
        bit  got;
        load_model(addr, len);
        stall_en = stall;
        d0 = done_cnt;
        pulse_start(addr, len);
        if (lat) begin
            check_val("lat_c1_busy", 128'(dma_wr_busy), 128'(1));
            check_val("lat_c1_tvalid", 128'(bus.s_axis_rq_tvalid), 128'(0));
            check_val("lat_c1_done", 128'(dma_wr_done), 128'(0));
            @(posedge pcie_clk);
            #2;
            if (len[31:4] == '0) begin
                check_val("zero_len_done_c2", 128'(dma_wr_done), 128'(1));
                check_val("zero_len_busy_c2", 128'(dma_wr_busy), 128'(0));
            end else begin
                check_val("lat_c2_tvalid", 128'(bus.s_axis_rq_tvalid), 128'(1));
            end
        end
        if (poke) begin
            repeat (2) @(posedge pcie_clk);
            #2;
            dma_wr_start = 1'b1;
            dma_wr_addr = 32'hDEAD_0000;
            dma_wr_len = 32'h0000_0100;
            @(posedge pcie_clk);
            #2;
            dma_wr_start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(posedge pcie_clk);
            if (done_cnt != d0) got = 1'b1;
        end
        check_val("done_seen", 128'(got), 128'(1));
        repeat (4) @(negedge pcie_clk);
        check_val("done_once", 128'(done_cnt - d0), 128'(1));
        check_val("src_consumed", 128'(src_idx), 128'(src_n));
        check_val("idle_busy", 128'(dma_wr_busy), 128'(0));
    endtask

    task automatic check_hdr(input int i, input logic [31:0] addr, input int dw, input int tag);
        if (obs_q.size() > i) begin
            check_val("tlp_addr", 128'(obs_q[i].addr), 128'(addr));
            check_val("tlp_dwcnt", 128'(obs_q[i].dw), 128'(dw));
            check_val("tlp_tag", 128'(obs_q[i].tag), 128'(tag));
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rl;
        int          d0;
        bit          got;

        repeat (3) @(posedge pcie_clk);
        #2;
        check_val("rst_tvalid", 128'(bus.s_axis_rq_tvalid), 128'(0));
        check_val("rst_tlast", 128'(bus.s_axis_rq_tlast), 128'(0));
        check_val("rst_tdata", bus.s_axis_rq_tdata, 128'(0));
        check_val("rst_tkeep", 128'(bus.s_axis_rq_tkeep), 128'(0));
        check_val("rst_tuser", 128'(bus.s_axis_rq_tuser), 128'(0));
        check_val("rst_src_tready", 128'(bus.src_tready), 128'(0));
        check_val("rst_busy", 128'(dma_wr_busy), 128'(0));
        check_val("rst_done", 128'(dma_wr_done), 128'(0));
        @(negedge pcie_clk);
        pcie_rst_n = 1'b1;

        // Single 64-byte TLP with latency checks.
        obs_q.delete();
        dbeats = 0;
        run_xfer(32'h1000_0000, 32'd64, 1'b0, 1'b1, 1'b0);
        check_val("one_tlp_count", 128'(obs_q.size()), 128'(1));
        check_hdr(0, 32'h1000_0000, 16, 0);
        check_val("one_tlp_beats", 128'(dbeats), 128'(4));

        // 608 bytes from 0: 256/256/96.
        do_reset();
        obs_q.delete();
        run_xfer(32'h0, 32'd608, 1'b0, 1'b0, 1'b0);
        check_val("split3_count", 128'(obs_q.size()), 128'(3));
        check_hdr(0, 32'h000, 64, 0);
        check_hdr(1, 32'h100, 64, 1);
        check_hdr(2, 32'h200, 24, 2);

        // 4 KB boundary crossing.
        do_reset();
        obs_q.delete();
        run_xfer(32'h0000_0FC0, 32'd256, 1'b1, 1'b0, 1'b0);
        check_val("4k_count", 128'(obs_q.size()), 128'(2));
        check_hdr(0, 32'h0000_0FC0, 16, 0);
        check_hdr(1, 32'h0000_1000, 48, 1);

        // Address wraps past the top of the 32-bit space.
        obs_q.delete();
        run_xfer(32'hFFFF_FF80, 32'd256, 1'b1, 1'b0, 1'b0);
        check_val("wrap_count", 128'(obs_q.size()), 128'(2));
        check_hdr(0, 32'hFFFF_FF80, 32, 2);
        check_hdr(1, 32'h0000_0000, 32, 3);

        // 1 KB under random stalls on both sides, then random transfers.
        run_xfer({$urandom_range(0, 32'hFFFF_FFFF) & 32'hFFFF_FFF0}, 32'd1024, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            ra = $urandom & 32'hFFFF_FFF0;
            if (k % 2 == 0) ra[11:4] = 8'hF0 | 8'($urandom_range(0, 15));
            rl = 32'($urandom_range(1, 200) * 16) | 32'($urandom_range(0, 15));
            run_xfer(ra, rl, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // Zero length, then a start pulse while busy.
        run_xfer(32'h0000_1230, 32'd0, 1'b0, 1'b1, 1'b0);
        run_xfer(32'h2000_0040, 32'd512, 1'b1, 1'b0, 1'b1);

        // Reset during the second payload beat.
        do_reset();
        load_model(32'h0, 32'd256);
        stall_en = 1'b0;
        dbeats = 0;
        pulse_start(32'h0, 32'd256);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge pcie_clk);
            if (dbeats >= 1) got = 1'b1;
        end
        check_val("rst_mid_reached", 128'(got), 128'(1));
        #2;
        check_val("rst_mid_pre_tvalid", 128'(bus.s_axis_rq_tvalid), 128'(1));
        check_val("rst_mid_pre_data", bus.s_axis_rq_tdata, src_mem[1]);
        pcie_rst_n = 1'b0;
        #1;
        check_val("rst_mid_tvalid", 128'(bus.s_axis_rq_tvalid), 128'(0));
        check_val("rst_mid_src_tready", 128'(bus.src_tready), 128'(0));
        check_val("rst_mid_busy", 128'(dma_wr_busy), 128'(0));
        check_val("rst_mid_done", 128'(dma_wr_done), 128'(0));
        exp_q.delete();
        src_n = 0;
        src_idx = 0;
        tag_m = 0;
        d0 = done_cnt;
        repeat (3) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        repeat (10) @(negedge pcie_clk);
        check_val("rst_mid_no_done", 128'(done_cnt), 128'(d0));
        check_val("rst_mid_idle_tvalid", 128'(bus.s_axis_rq_tvalid), 128'(0));
        check_val("rst_mid_idle_busy", 128'(dma_wr_busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
